// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the shared memory port.
// The slave modport is the arbiter's view; master is the requesters'/memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [STRB_W-1:0] core_wstrb;
    logic              core_gnt;
    logic              core_ack;
    logic [DATA_W-1:0] core_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [STRB_W-1:0] dbg_wstrb;
    logic              dbg_gnt;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_wstrb,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
        input  mem_rdata,
        output core_gnt, core_ack, core_rdata,
        output dbg_gnt, dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output busy, owner
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_wstrb,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
        output mem_rdata,
        input  core_gnt, core_ack, core_rdata,
        input  dbg_gnt, dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a fixed-latency synchronous memory: core has priority,
// the debug agent is forced through after STARVE_MAX consecutive core wins.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [2:0]       LAT_LOAD   = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  starve_cnt;
    logic [2:0]        lat_cnt;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              dbg_win;
    logic              core_win;
    logic              done;

    always_comb begin
        dbg_win    = 1'b0;
        core_win   = 1'b0;
        state_next = state;
        // Grants are only offered from IDLE and never while reset is held
        if (state == IDLE && !rst) begin
            dbg_win  = bus.dbg_req && (!bus.core_req || starve_cnt == STARVE_LIM);
            core_win = bus.core_req && !dbg_win;
        end
        case (state)
            IDLE:    if (dbg_win || core_win) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (lat_cnt == 3'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state <= state_next;
            if (dbg_win) begin
                owner_q    <= 1'b1;
                we_q       <= bus.dbg_we;
                addr_q     <= bus.dbg_addr;
                wdata_q    <= bus.dbg_wdata;
                wstrb_q    <= bus.dbg_wstrb;
                starve_cnt <= '0;
            end else if (core_win) begin
                owner_q <= 1'b0;
                we_q    <= bus.core_we;
                addr_q  <= bus.core_addr;
                wdata_q <= bus.core_wdata;
                wstrb_q <= bus.core_wstrb;
                if (bus.dbg_req && starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 1'b1;
            end
            if (state == ISSUE)
                lat_cnt <= LAT_LOAD;
            else if (state == WAIT)
                lat_cnt <= lat_cnt - 3'd1;
        end
    end

    always_comb begin
        done           = (state == WAIT) && (lat_cnt == 3'd1) && !rst;
        bus.core_gnt   = core_win;
        bus.dbg_gnt    = dbg_win;
        bus.core_ack   = done && !owner_q;
        bus.dbg_ack    = done && owner_q;
        bus.core_rdata = (bus.core_ack && !we_q) ? bus.mem_rdata : '0;
        bus.dbg_rdata  = (bus.dbg_ack && !we_q) ? bus.mem_rdata : '0;
        bus.mem_en     = (state == ISSUE);
        bus.mem_we     = (state == ISSUE) && we_q;
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = wdata_q;
        bus.mem_wstrb  = wstrb_q;
        bus.busy       = (state != IDLE);
        bus.owner      = owner_q;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between two requesters: the core, which issues both instruction fetches and load/store accesses, and a debug/DMA agent.
- Sequences one outstanding transaction at a time through a fixed-latency synchronous memory.
- Core has priority; the debug agent is protected against starvation by a counter.
- Sits between the multicycle control unit/datapath and the memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MEM_LAT, 2, memory read latency in cycles (1..4), from mem_en cycle to mem_rdata valid
STARVE_MAX, 4, consecutive core wins while dbg pending before dbg is forced (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_req  in  1  core request, held until core_gnt
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  address
core_wdata  in  DATA_W  write data
core_wstrb  in  DATA_W/8  byte strobes
core_gnt  out  1  request accepted (one-cycle pulse)
core_ack  out  1  transaction complete (one-cycle pulse)
core_rdata  out  DATA_W  read data, valid with core_ack
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb, dbg_gnt, dbg_ack, dbg_rdata: identical to core_* for the debug requester
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte strobes
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE
owner  out  1  0=core, 1=dbg; owner of the current or last transaction

Behaviour:
- Reset: one clock; reset is synchronous and active-high, on clk rising edge with rst=1.
- Reset values: state=IDLE, starve_cnt=0, owner=0, latched addr/wdata/wstrb/we=0, all gnt/ack/mem_en/mem_we=0, rdata outputs=0, busy=0.
- Reset mid-transaction: the transaction is dropped, no ack is issued, mem_en=0 from the next cycle.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE: if any req, arbitrate combinationally and assert the winner's gnt in this cycle.
  - At the clock edge, capture the winner's we/addr/wdata/wstrb, set owner, go to ISSUE.
  - The requester may change or drop its fields after gnt.
  - No req: stay in IDLE.
- Arbitration:
  - dbg wins if dbg_req && (!core_req || starve_cnt==STARVE_MAX). Otherwise core wins if core_req.
  - starve_cnt increments when core wins with dbg_req=1.
  - starve_cnt clears when dbg wins.
  - starve_cnt is unchanged otherwise.
  - starve_cnt saturates at STARVE_MAX.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_we=latched we.
  - mem_addr/wdata/wstrb = latched values, which are held stable outside ISSUE.
  - Load latency counter with MEM_LAT, go to WAIT.
- WAIT: counter decrements each cycle. In the cycle where the counter reaches 1 (MEM_LAT cycles after the ISSUE cycle):
  - owner's ack=1.
  - owner's rdata = mem_rdata if read, 0 if write.
  - Next state is IDLE.
  - Writes use the same timing as reads.
- Non-owner ack=0 and rdata=0 at all times.
- Timing: gnt at T, mem_en at T+1, ack at T+1+MEM_LAT, next gnt earliest at T+2+MEM_LAT.
- Requests arriving while busy are ignored until IDLE; gnt is never asserted outside IDLE.
- At most one gnt and one ack are active per cycle.

Test Plan:
1. MEM_LAT=2; core read at cycle 0, addr 0x100; memory returns 0xDEADBEEF at cycle 3 -> core_gnt@0, mem_en=1 mem_we=0 mem_addr=0x100 @1, core_ack=1 core_rdata=0xDEADBEEF @3, busy 1..3, next gnt possible @4.
2. core_req and dbg_req both asserted at cycle 0 -> core_gnt@0; dbg_gnt@4; dbg_ack@7; owner=1 from cycle 5.
3. STARVE_MAX=4; core_req and dbg_req held high continuously -> grant sequence C,C,C,C,D,C,C,C,C,D; starve_cnt returns to 0 after each D.
4. dbg write addr 0x20, wdata 0x12345678, wstrb 0xF at cycle 0 -> mem_en=1 mem_we=1 mem_wdata=0x12345678 mem_wstrb=0xF @1; dbg_ack@3 with dbg_rdata=0; core_ack stays 0.
5. rst=1 at cycle 2 of a core read (state WAIT) -> no core_ack, busy=0 and mem_en=0 @3; new dbg read at cycle 4 is granted @4 and completes normally with starve_cnt=0.
6. MEM_LAT=1 build; back-to-back core reads -> gnt@0, mem_en@1, ack@2, gnt@3, mem_en@4, ack@5.
